// File: rtl/led_shifter_pkg.sv
// led_shifter_pkg: shared mode and direction types for the LED shifter
package led_shifter_pkg;
  typedef enum logic [1:0] {
    MODE_SAT  = 2'b00,
    MODE_WRAP = 2'b01,
    MODE_AUTO = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;
endpackage

// File: rtl/led_shifter_if.sv
// led_shifter_if: button/mode inputs and LED/pos outputs of the LED shifter
//   btnL, btnR, btnC : raw buttons (master drives)
//   mode             : 00 SAT, 01 WRAP, 10 AUTO, 11 as SAT
//   LED              : one-hot display (slave drives)
//   pos              : index of the lit LED (slave drives)
interface led_shifter_if #(parameter int N_LED = 16);
  logic btnL;
  logic btnR;
  logic btnC;
  logic [1:0] mode;
  logic [N_LED-1:0] LED;
  logic [$clog2(N_LED)-1:0] pos;
  modport master (output btnL, btnR, btnC, mode, input LED, pos);
  modport slave (input btnL, btnR, btnC, mode, output LED, pos);
endinterface

// File: rtl/led_shifter_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, level debouncer and one-cycle rising-edge pulse
//   clk, rst : clock, synchronous active-high reset
//   din      : raw asynchronous button
//   level    : debounced level
//   rise     : one-cycle pulse when level goes 0->1
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic accept;
  // the current sample is the DEBOUNCE_CYC-th consecutive one differing from level
  assign accept = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      level <= accept ? sync[1] : level;
      cnt   <= (sync[1] == level || accept) ? '0 : cnt + CW'(1);
      rise  <= accept & sync[1];
    end
  end
endmodule

// File: rtl/led_shifter.sv
// led_shifter: single-dot LED bar moved by debounced buttons with SAT/WRAP/AUTO end behaviour
//   clk, rst : clock, synchronous active-high reset
//   bus      : led_shifter_if slave (btnL/btnR/btnC/mode in, LED/pos out)
//   Macro LED_SHIFTER_AUTORUN_EN enables the AUTO bounce mode (tick counter + dir);
//   without it mode 10 behaves as SAT and TICK_DIV is ignored.
module led_shifter
  import led_shifter_pkg::*;
#(
  parameter int N_LED        = 16,
  parameter int START_POS    = 8,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TICK_DIV     = 25_000_000
) (
  input logic clk,
  input logic rst,
  led_shifter_if.slave bus
);
  localparam int PW = $clog2(N_LED);
  localparam logic [PW-1:0] TOP = PW'(N_LED - 1);
  localparam logic [PW-1:0] START = PW'(START_POS);
  logic l_rise, r_rise, c_rise;
  logic [2:0] lvl_unused;
  logic [PW-1:0] pos_q, pos_n, up_n, dn_n;
  logic [N_LED-1:0] led_q;
  logic move_l, move_r, wrap;
  mode_e m;
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_l (.clk(clk), .rst(rst), .din(bus.btnL), .level(lvl_unused[0]), .rise(l_rise));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_r (.clk(clk), .rst(rst), .din(bus.btnR), .level(lvl_unused[1]), .rise(r_rise));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_c (.clk(clk), .rst(rst), .din(bus.btnC), .level(lvl_unused[2]), .rise(c_rise));
  assign m      = mode_e'(bus.mode);
  assign wrap   = m == MODE_WRAP;
  assign move_l = l_rise & ~r_rise;
  assign move_r = r_rise & ~l_rise;
  assign up_n   = pos_q == TOP ? (wrap ? '0 : pos_q) : pos_q + PW'(1);
  assign dn_n   = pos_q == '0 ? (wrap ? TOP : pos_q) : pos_q - PW'(1);
`ifdef LED_SHIFTER_AUTORUN_EN
  localparam int TW = $clog2(TICK_DIV);
  logic [TW-1:0] tick_q;
  dir_e dir_q, dir_n;
  logic auto, tick, at_top, at_bot;
  assign auto   = m == MODE_AUTO;
  assign tick   = auto && tick_q == TW'(TICK_DIV - 1);
  assign at_top = pos_q == TOP;
  assign at_bot = pos_q == '0;
  // in AUTO the buttons only steer; a tick colliding with any L/R edge is dropped
  always_comb begin
    pos_n = pos_q;
    dir_n = dir_q;
    if (c_rise) begin
      pos_n = START;
      dir_n = DIR_UP;
    end else if (auto) begin
      if (move_l) dir_n = DIR_UP;
      else if (move_r) dir_n = DIR_DOWN;
      else if (tick && !l_rise && !r_rise) begin
        if (dir_q == DIR_UP) begin
          pos_n = at_top ? pos_q - PW'(1) : pos_q + PW'(1);
          dir_n = at_top ? DIR_DOWN : DIR_UP;
        end else begin
          pos_n = at_bot ? pos_q + PW'(1) : pos_q - PW'(1);
          dir_n = at_bot ? DIR_UP : DIR_DOWN;
        end
      end
    end else pos_n = move_l ? up_n : move_r ? dn_n : pos_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      dir_q  <= DIR_UP;
    end else begin
      tick_q <= (c_rise || !auto || tick) ? '0 : tick_q + TW'(1);
      dir_q  <= dir_n;
    end
  end
`else
  localparam int tick_div_unused = TICK_DIV;
  assign pos_n = c_rise ? START : move_l ? up_n : move_r ? dn_n : pos_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= START;
      led_q <= N_LED'(1) << START;
    end else begin
      pos_q <= pos_n;
      led_q <= N_LED'(1) << pos_n;
    end
  end
  assign bus.pos = pos_q;
  assign bus.LED = led_q;
endmodule

// File: tb/tb_led_shifter.sv
// tb_led_shifter: directed self-checking bench for led_shifter (N_LED=16, START_POS=8, DEBOUNCE_CYC=4, TICK_DIV=8)
module tb_led_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  led_shifter_if #(.N_LED(16)) bus ();
  led_shifter #(.N_LED(16), .START_POS(8), .DEBOUNCE_CYC(4), .TICK_DIV(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic press(input logic l, input logic r, input logic c);
    @(negedge clk);
    bus.btnL = l;
    bus.btnR = r;
    bus.btnC = c;
    repeat (8) @(negedge clk);
    bus.btnL = 1'b0;
    bus.btnR = 1'b0;
    bus.btnC = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.pos !== 4'd8) begin errors++; $display("FAIL reset_pos: got %0d expected 8", bus.pos); end
    checks++; if (bus.LED !== 16'h0100) begin errors++; $display("FAIL reset_led: got %h expected 0100", bus.LED); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (bus.pos !== 4'd8) begin errors++; $display("FAIL idle_pos: got %0d expected 8", bus.pos); end
    checks++; if (bus.LED !== 16'h0100) begin errors++; $display("FAIL idle_led: got %h expected 0100", bus.LED); end
    bus.btnL = 1'b1;
    repeat (3) @(negedge clk);
    bus.btnL = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (bus.pos !== 4'd8) begin errors++; $display("FAIL glitch_pos: got %0d expected 8", bus.pos); end
    checks++; if (bus.LED !== 16'h0100) begin errors++; $display("FAIL glitch_led: got %h expected 0100", bus.LED); end
  endtask
  task automatic test_sat;
    logic [3:0] exp;
    bus.mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      press(1'b1, 1'b0, 1'b0);
      exp = (9 + i > 15) ? 4'd15 : 4'(9 + i);
      checks++; if (bus.pos !== exp) begin errors++; $display("FAIL sat_press%0d: got %0d expected %0d", i, bus.pos, exp); end
    end
    checks++; if (bus.LED !== 16'h8000) begin errors++; $display("FAIL sat_led_top: got %h expected 8000", bus.LED); end
    press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.pos !== 4'd15) begin errors++; $display("FAIL sat_hold_top: got %0d expected 15", bus.pos); end
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++; if (bus.pos !== 4'd13) begin errors++; $display("FAIL sat_down2: got %0d expected 13", bus.pos); end
    @(negedge clk);
    bus.btnL = 1'b1;
    repeat (100) @(negedge clk);
    bus.btnL = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (bus.pos !== 4'd14) begin errors++; $display("FAIL sat_held: got %0d expected 14", bus.pos); end
    checks++; if (bus.LED !== 16'h4000) begin errors++; $display("FAIL sat_held_led: got %h expected 4000", bus.LED); end
  endtask
  task automatic test_wrap;
    bus.mode = 2'b01;
    press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.pos !== 4'd15) begin errors++; $display("FAIL wrap_to15: got %0d expected 15", bus.pos); end
    press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.pos !== 4'd0) begin errors++; $display("FAIL wrap_l_to0: got %0d expected 0", bus.pos); end
    checks++; if (bus.LED !== 16'h0001) begin errors++; $display("FAIL wrap_led0: got %h expected 0001", bus.LED); end
    @(negedge clk);
    bus.btnR = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd0) begin errors++; $display("FAIL wrap_r_early: got %0d expected 0", bus.pos); end
    @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd15) begin errors++; $display("FAIL wrap_r_lat7: got %0d expected 15", bus.pos); end
    checks++; if (bus.LED !== 16'h8000) begin errors++; $display("FAIL wrap_r_led: got %h expected 8000", bus.LED); end
    repeat (3) @(negedge clk);
    bus.btnR = 1'b0;
    repeat (12) @(negedge clk);
    press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.pos !== 4'd0) begin errors++; $display("FAIL wrap_back0: got %0d expected 0", bus.pos); end
  endtask
  task automatic test_simultaneous;
    bus.mode = 2'b00;
    press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.pos !== 4'd1) begin errors++; $display("FAIL simul_setup: got %0d expected 1", bus.pos); end
    press(1'b1, 1'b1, 1'b0);
    checks++; if (bus.pos !== 4'd1) begin errors++; $display("FAIL simul_lr: got %0d expected 1", bus.pos); end
    press(1'b1, 1'b0, 1'b1);
    checks++; if (bus.pos !== 4'd8) begin errors++; $display("FAIL simul_cl: got %0d expected 8", bus.pos); end
    checks++; if (bus.LED !== 16'h0100) begin errors++; $display("FAIL simul_cl_led: got %h expected 0100", bus.LED); end
  endtask
`ifdef LED_SHIFTER_AUTORUN_EN
  task automatic test_auto;
    for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.pos !== 4'd14) begin errors++; $display("FAIL auto_setup: got %0d expected 14", bus.pos); end
    @(negedge clk);
    bus.mode = 2'b10;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd15) begin errors++; $display("FAIL auto_t8: got %0d expected 15", bus.pos); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd14) begin errors++; $display("FAIL auto_t16: got %0d expected 14", bus.pos); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd13) begin errors++; $display("FAIL auto_t24: got %0d expected 13", bus.pos); end
    checks++; if (bus.LED !== 16'h2000) begin errors++; $display("FAIL auto_t24_led: got %h expected 2000", bus.LED); end
    @(negedge clk);
    bus.mode = 2'b00;
    @(negedge clk);
    bus.mode = 2'b10;
    bus.btnL = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd13) begin errors++; $display("FAIL auto_l_nomove: got %0d expected 13", bus.pos); end
    @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd14) begin errors++; $display("FAIL auto_l_up: got %0d expected 14", bus.pos); end
    @(negedge clk);
    bus.btnL = 1'b0;
    bus.btnR = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd14) begin errors++; $display("FAIL auto_r_nomove: got %0d expected 14", bus.pos); end
    @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd13) begin errors++; $display("FAIL auto_r_down: got %0d expected 13", bus.pos); end
    @(negedge clk);
    bus.btnR = 1'b0;
    bus.mode = 2'b00;
    repeat (12) @(negedge clk);
  endtask
`else
  task automatic test_auto;
    bus.mode = 2'b10;
    press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.pos !== 4'd9) begin errors++; $display("FAIL auto_as_sat: got %0d expected 9", bus.pos); end
    repeat (40) @(negedge clk);
    checks++; if (bus.pos !== 4'd9) begin errors++; $display("FAIL auto_no_tick: got %0d expected 9", bus.pos); end
    bus.mode = 2'b00;
  endtask
`endif
  task automatic test_reset_mid;
    @(negedge clk);
    bus.mode = 2'b10;
    bus.btnL = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.btnL = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.pos !== 4'd8) begin errors++; $display("FAIL rstmid_pos: got %0d expected 8", bus.pos); end
    checks++; if (bus.LED !== 16'h0100) begin errors++; $display("FAIL rstmid_led: got %h expected 0100", bus.LED); end
    @(negedge clk);
    rst = 1'b0;
    bus.mode = 2'b00;
    repeat (30) @(negedge clk);
    checks++; if (bus.pos !== 4'd8) begin errors++; $display("FAIL rstmid_stray: got %0d expected 8", bus.pos); end
    checks++; if (bus.LED !== 16'h0100) begin errors++; $display("FAIL rstmid_stray_led: got %h expected 0100", bus.LED); end
  endtask
  initial begin
    bus.btnL = 1'b0;
    bus.btnR = 1'b0;
    bus.btnC = 1'b0;
    bus.mode = 2'b00;
    test_reset;
    test_sat;
    test_wrap;
    test_simultaneous;
    test_auto;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
